out_serializer: RTL and testbench

OUT_SERIALIZER -- requirements
Module: out_serializer

---
 rtl/out_serializer.sv | 143 ++++++++++++++
 tb/tb_out_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/out_serializer.sv
// rtl/out_serializer.sv - one-word buffered LSB-first parallel-to-serial output stage
// Optional trailing even-parity bit: define OUT_SERIALIZER_PARITY_EN.
module out_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VLD,
  output logic             DIN_RDY,
  output logic             OQI,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef OUT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             oqi_q, oqi_n;
  logic             done_q, done_n;
  logic             load;
`ifdef OUT_SERIALIZER_PARITY_EN
  logic             par, par_n;
`endif

  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      oqi_q     <= IDLE_LEVEL;
      done_q    <= 1'b0;
`ifdef OUT_SERIALIZER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      oqi_q     <= oqi_n;
      done_q    <= done_n;
`ifdef OUT_SERIALIZER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    hold_n      = hold;
    hold_full_n = hold_full;
    shreg_n     = shreg;
    cnt_n       = cnt;
    oqi_n       = oqi_q;
    done_n      = 1'b0;
    load        = 1'b0;
`ifdef OUT_SERIALIZER_PARITY_EN
    par_n       = par;
`endif

    // Accept only when empty; a load needs a full holding register, so both never coincide.
    if (DIN_VLD && !hold_full) begin
      hold_n      = DIN;
      hold_full_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (hold_full) load = 1'b1;
      end
      SHIFT: begin
        if (cnt == LAST) begin
`ifdef OUT_SERIALIZER_PARITY_EN
          state_n = PARITY;
          oqi_n   = par;
          done_n  = 1'b1;
`else
          if (hold_full) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            oqi_n   = IDLE_LEVEL;
          end
`endif
        end else begin
          cnt_n   = cnt + CW'(1);
          shreg_n = shreg >> 1;
          oqi_n   = shreg[1];
`ifndef OUT_SERIALIZER_PARITY_EN
          done_n  = (cnt_n == LAST);
`endif
        end
      end
`ifdef OUT_SERIALIZER_PARITY_EN
      PARITY: begin
        if (hold_full) begin
          load = 1'b1;
        end else begin
          state_n = IDLE;
          oqi_n   = IDLE_LEVEL;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        oqi_n   = IDLE_LEVEL;
      end
    endcase

    if (load) begin
      state_n     = SHIFT;
      shreg_n     = hold;
      cnt_n       = '0;
      oqi_n       = hold[0];
      hold_full_n = 1'b0;
`ifdef OUT_SERIALIZER_PARITY_EN
      par_n       = ^hold;
`endif
    end
  end

  assign DIN_RDY = !hold_full;
  assign OQI     = oqi_q;
  assign BUSY    = (state != IDLE);
  assign DONE    = done_q;

endmodule

// File: tb/tb_out_serializer.sv
// tb/tb_out_serializer.sv - directed self-checking bench for out_serializer (WIDTH=8)
module tb_out_serializer;

`ifdef OUT_SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       IQC;
  logic       QRT;
  logic [7:0] DIN;
  logic       DIN_VLD;
  logic       DIN_RDY;
  logic       OQI;
  logic       BUSY;
  logic       DONE;

  int n_chk  = 0;
  int n_pass = 0;

  logic       s_oqi  [0:31];
  logic       s_busy [0:31];
  logic       s_done [0:31];
  logic [7:0] wq [$];
  logic [7:0] ew [$];

  out_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
    .IQC     (IQC),
    .QRT     (QRT),
    .DIN     (DIN),
    .DIN_VLD (DIN_VLD),
    .DIN_RDY (DIN_RDY),
    .OQI     (OQI),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  initial IQC = 1'b0;
  always #5 IQC = ~IQC;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Sample at each falling edge, then offer the next queued word whenever the holding register is empty.
  task automatic run(input int ncyc, input bit junk);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge IQC);
      s_oqi[i]  = OQI;
      s_busy[i] = BUSY;
      s_done[i] = DONE;
      if (DIN_RDY && wq.size() > 0) begin
        DIN     = wq.pop_front();
        DIN_VLD = 1'b1;
      end else if (junk && !DIN_RDY) begin
        DIN     = 8'($urandom);
        DIN_VLD = 1'b1;
      end else begin
        DIN_VLD = 1'b0;
      end
    end
    DIN_VLD = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int n);
    logic [31:0] go, gb, gd, eo, eb, ed;
    logic [7:0]  w;
    int len, p, f, k;
    len = 2 + n * FL + 2;
    go = '0; gb = '0; gd = '0; eo = '0; eb = '0; ed = '0;
    for (int i = 0; i < len; i++) begin
      go[i] = s_oqi[i];
      gb[i] = s_busy[i];
      gd[i] = s_done[i];
      p = i - 2;
      if (i >= 2 && p < n * FL) begin
        f = p / FL;
        k = p % FL;
        w = ew[f];
        eb[i] = 1'b1;
        eo[i] = (k < 8) ? w[k] : ^w;
        ed[i] = (k == FL - 1);
      end else begin
        eo[i] = 1'b1;
      end
    end
    check({tag, "_oqi"},  go, eo);
    check({tag, "_busy"}, gb, eb);
    check({tag, "_done"}, gd, ed);
  endtask

  function automatic logic [7:0] frame_byte(input int start);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = s_oqi[start + k];
    return b;
  endfunction

  initial begin
    logic [31:0] v;
    QRT     = 1'b1;
    DIN     = 8'h00;
    DIN_VLD = 1'b0;
    repeat (2) @(negedge IQC);
    check("rst_oqi",  32'(OQI),     32'd1);
    check("rst_busy", 32'(BUSY),    32'd0);
    check("rst_done", 32'(DONE),    32'd0);
    check("rst_rdy",  32'(DIN_RDY), 32'd1);
    QRT = 1'b0;

    // single frame
    wq = '{8'hA5};
    ew = wq;
    run(2 + FL + 2, 1'b0);
    check_stream("single", 1);
    check("single_byte", 32'(frame_byte(2)), 32'h0000_00A5);
    check("single_rdy_during_hold", 32'(s_busy[1]), 32'd0);

    // back-to-back frames
    wq = '{8'hA5, 8'h3C};
    ew = wq;
    run(2 + 2 * FL + 2, 1'b0);
    check_stream("b2b", 2);
    check("b2b_byte1", 32'(frame_byte(2 + FL)), 32'h0000_003C);
`ifdef OUT_SERIALIZER_PARITY_EN
    check("par_a5", 32'(s_oqi[2 + 8]), 32'd0);
`endif

    // stalled offers with changing junk must be ignored
    wq = '{8'h5A, 8'hC3, 8'h81};
    ew = wq;
    run(2 + 3 * FL + 2, 1'b1);
    check_stream("stall", 3);

`ifdef OUT_SERIALIZER_PARITY_EN
    wq = '{8'hA5, 8'h07};
    ew = wq;
    run(2 + 2 * FL + 2, 1'b0);
    check_stream("par", 2);
    check("par_07", 32'(s_oqi[2 + FL + 8]), 32'd1);
`endif

    // async reset mid-frame of 0xFF with 0x00 held
    wq = '{8'hFF, 8'h00};
    run(6, 1'b0);
    check("pre_rst_rdy", 32'(DIN_RDY), 32'd0);
    #2 QRT = 1'b1;
    #1;
    check("arst_oqi",  32'(OQI),     32'd1);
    check("arst_busy", 32'(BUSY),    32'd0);
    check("arst_rdy",  32'(DIN_RDY), 32'd1);
    check("arst_done", 32'(DONE),    32'd0);
    @(negedge IQC);
    QRT = 1'b0;
    run(12, 1'b0);
    v = '0;
    for (int i = 0; i < 12; i++) v[i] = s_oqi[i];
    check("post_rst_oqi", v, 32'h0000_0FFF);
    v = '0;
    for (int i = 0; i < 12; i++) v[i] = s_busy[i];
    check("post_rst_busy", v, 32'h0);

    // one-cycle reset while idle, then accept on the first edge after release
    @(posedge IQC);
    #1 QRT = 1'b1;
    #1 check("idle_rst_oqi", 32'(OQI), 32'd1);
    @(posedge IQC);
    #1 QRT = 1'b0;
    check("idle_rel_oqi", 32'(OQI), 32'd1);
    wq = '{8'h01};
    ew = wq;
    run(2 + FL + 2, 1'b0);
    check_stream("after_rst", 1);
    check("after_rst_byte", 32'(frame_byte(2)), 32'h0000_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
